// File: rtl/a25_wb_arb2.sv
// Two-master Wishbone arbiter in front of the shared Wishbone-to-AXI-Lite bridge port.
// Master 0 is the A25 core, master 1 a secondary initiator (DMA/debug).
// Whole cyc-framed cycles are granted, round-robin or fixed-priority, and a bus
// watchdog aborts slave transfers that never complete.
//
// Handshake: a master requests with cyc & stb. Its request is granted at the next
// edge, and the slave sees that master's cyc/stb from then on. A transfer completes
// in any cycle where the owner has stb high and the slave raises ack or err. Only
// the current owner ever sees ack/err. The grant is held until the owner drops cyc,
// and there is always one IDLE cycle between owners.
module a25_wb_arb2 #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 128,
  parameter int WB_SW      = WB_DW >> 3,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [WB_AW-1:0] i_m0_adr,
  input  logic [WB_SW-1:0] i_m0_sel,
  input  logic [WB_DW-1:0] i_m0_dat,
  output logic [WB_DW-1:0] o_m0_dat,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [WB_AW-1:0] i_m1_adr,
  input  logic [WB_SW-1:0] i_m1_sel,
  input  logic [WB_DW-1:0] i_m1_dat,
  output logic [WB_DW-1:0] o_m1_dat,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic             o_s_cyc,
  output logic             o_s_stb,
  output logic             o_s_we,
  output logic [WB_AW-1:0] o_s_adr,
  output logic [WB_SW-1:0] o_s_sel,
  output logic [WB_DW-1:0] o_s_dat,
  input  logic [WB_DW-1:0] i_s_dat,
  input  logic             i_s_ack,
  input  logic             i_s_err,
  output logic [1:0]       o_owner,
  output logic             o_timeout,
  output logic [1:0]       o_state
);

  // Watchdog sized to hold TIMEOUT; kept at least one bit wide when disabled.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t         state;
  logic           last;   // master granted most recently
  logic [WDW-1:0] wdog;

  logic req0, req1, owning, wd_count, wd_expire;

  assign req0   = i_m0_cyc & i_m0_stb;
  assign req1   = i_m1_cyc & i_m1_stb;
  assign owning = (state == OWN0) || (state == OWN1);

  // The watchdog only runs while a granted strobe is waiting for an answer.
  assign wd_count  = (TIMEOUT != 0) && owning && o_s_stb && !(i_s_ack || i_s_err);
  assign wd_expire = wd_count && (wdog == WD_LAST);

  assign o_state  = state;
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;

  // Arbitration FSM, last-grant tracking and bus watchdog.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (req0 && req1) begin
            if ((FIXED_PRIO != 0) || last) begin
              state <= OWN0;
              last  <= 1'b0;
            end else begin
              state <= OWN1;
              last  <= 1'b1;
            end
          end else if (req0) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (req1) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (wd_expire) begin
            state <= ABORT;
            wdog  <= '0;
          end else if ((state == OWN0) ? !i_m0_cyc : !i_m1_cyc) begin
            state <= IDLE;
            wdog  <= '0;
          end else begin
            wdog <= wd_count ? wdog + 1'b1 : '0;
          end
        end
        default: begin
          state <= IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

  // Slave-side mux and master returns, decoded from the registered state.
  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_adr   = '0;
    o_s_sel   = '0;
    o_s_dat   = '0;
    o_m0_ack  = 1'b0;
    o_m0_err  = 1'b0;
    o_m1_ack  = 1'b0;
    o_m1_err  = 1'b0;
    o_owner   = 2'b00;
    o_timeout = 1'b0;
    case (state)
      OWN0: begin
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb;
        o_s_we   = i_m0_we;
        o_s_adr  = i_m0_adr;
        o_s_sel  = i_m0_sel;
        o_s_dat  = i_m0_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err;
        o_owner  = 2'b01;
      end
      OWN1: begin
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb;
        o_s_we   = i_m1_we;
        o_s_adr  = i_m1_adr;
        o_s_sel  = i_m1_sel;
        o_s_dat  = i_m1_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err;
        o_owner  = 2'b10;
      end
      ABORT: begin
        // The aborted owner is the one recorded at grant time; late slave
        // responses are not forwarded here.
        o_timeout = 1'b1;
        o_m0_err  = !last;
        o_m1_err  = last;
      end
      default: ;
    endcase
  end

endmodule
